// File: rtl/relprime_pkg.sv
// Shared definitions for the relprime engine: default datapath width and FSM state encoding.
package relprime_pkg;

    localparam int W_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        INIT  = 3'd2,
        STEP  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/gcd_sub_unit.sv
// Subtraction-Euclid gcd datapath: holds A/B and performs one subtraction per step.
// When eq is high, A holds the gcd.
module gcd_sub_unit
    import relprime_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] a_init,
    input  logic [W-1:0] b_init,
    output logic [W-1:0] a,
    output logic         eq
);

    logic [W-1:0] b;

    assign eq = (a == b);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a <= '0;
            b <= '0;
        end else if (load) begin
            a <= a_init;
            b <= b_init;
        end else if (step) begin
            // The larger operand is always the minuend, so no underflow.
            if (a > b) begin
                a <= a - b;
            end else if (b > a) begin
                b <= b - a;
            end
        end
    end

endmodule

// File: rtl/top_level.sv
// Relprime engine: finds the smallest m >= decimal_two with gcd(register_value, m) == decimal_one,
// stepping m by decimal_one and using gcd_sub_unit for the gcd.
module top_level
    import relprime_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [W-1:0] register_value,
    input  logic [W-1:0] decimal_two,
    input  logic [W-1:0] decimal_one,
    input  logic         start,
    output logic [W-1:0] out,
    output logic         done
);

    state_t       state;
    logic [W-1:0] n_reg;
    logic [W-1:0] m_reg;
    logic [W-1:0] one_reg;
    logic [W-1:0] m_next;
    logic [W-1:0] gcd_a;
    logic         gcd_eq;
    logic         operand_zero;
    logic         load_ab;
    logic         step_ab;

    assign m_next       = m_reg + one_reg;
    assign operand_zero = (n_reg == '0) || (m_reg == '0);

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        load_ab = 1'b0;
        step_ab = 1'b0;
        if (!start) begin
            if (state == INIT && !operand_zero) begin
                load_ab = 1'b1;
            end
            if (state == STEP && !gcd_eq) begin
                step_ab = 1'b1;
            end
        end
    end

    gcd_sub_unit #(
        .W(W)
    ) u_gcd (
        .clk    (CLK),
        .rst_n  (RST_N),
        .load   (load_ab),
        .step   (step_ab),
        .a_init (n_reg),
        .b_init (m_reg),
        .a      (gcd_a),
        .eq     (gcd_eq)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            n_reg   <= '0;
            m_reg   <= '0;
            one_reg <= '0;
            out     <= '0;
            done    <= 1'b0;
        end else if (start) begin
            // Restart from any state; out keeps the old result until a new one lands.
            state   <= LOAD;
            n_reg   <= register_value;
            m_reg   <= decimal_two;
            one_reg <= decimal_one;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= IDLE;
                LOAD: state <= INIT;
                INIT: begin
                    if (operand_zero) begin
                        out   <= '0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= STEP;
                    end
                end
                STEP: begin
                    if (gcd_eq) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (gcd_a == one_reg) begin
                        out   <= m_reg;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        m_reg <= m_next;
                        // Candidate wrapped past 2^W-1: no answer in range.
                        if (m_next == '0) begin
                            out   <= '0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= INIT;
                        end
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: table of operand/expected-result vectors plus
// hand-written sequences for reset, restart and held-start behaviour.
module tb_top_level;
    import relprime_pkg::*;

    localparam int W = 16;

    logic         CLK;
    logic         RST_N;
    logic [W-1:0] register_value;
    logic [W-1:0] decimal_two;
    logic [W-1:0] decimal_one;
    logic         start;
    logic [W-1:0] out;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] n;
        logic [W-1:0] two;
        logic [W-1:0] one;
        logic [W-1:0] expected;
        int           max_cycles;
    } vec_t;

    vec_t vecs[9];

    top_level #(.W(W)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .register_value (register_value),
        .decimal_two    (decimal_two),
        .decimal_one    (decimal_one),
        .start          (start),
        .out            (out),
        .done           (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // One-cycle start pulse; the expected result goes to the scoreboard.
    task automatic pulse_start(input logic [W-1:0] n, input logic [W-1:0] two,
                               input logic [W-1:0] one, input logic [W-1:0] expected);
        @(negedge CLK);
        register_value = n;
        decimal_two    = two;
        decimal_one    = one;
        start          = 1'b1;
        exp_q.push_back(expected);
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(negedge CLK);
            cycles++;
        end
    endtask

    task automatic score(input string name);
        logic [W-1:0] expected;
        expected = exp_q.pop_front();
        check({name, "_done"}, {31'd0, done}, 32'd1);
        check({name, "_out"}, {16'd0, out}, {16'd0, expected});
    endtask

    initial begin
        int cycles;
        int hold_bad;

        vecs[0] = '{16'd1,     16'd2,     16'd1, 16'd2,     40000};
        vecs[1] = '{16'd6,     16'd2,     16'd1, 16'd5,     40000};
        vecs[2] = '{16'd0,     16'd2,     16'd1, 16'd0,     3};
        vecs[3] = '{16'd210,   16'd2,     16'd1, 16'd11,    40000};
        vecs[4] = '{16'd2310,  16'd2,     16'd1, 16'd13,    40000};
        vecs[5] = '{16'd9,     16'd0,     16'd1, 16'd0,     3};
        vecs[6] = '{16'd65535, 16'd65535, 16'd1, 16'd0,     40000};
        vecs[7] = '{16'd2,     16'd65535, 16'd1, 16'd65535, 40000};
        vecs[8] = '{16'd35,    16'd2,     16'd1, 16'd2,     40000};

        RST_N          = 1'b0;
        start          = 1'b0;
        register_value = '0;
        decimal_two    = '0;
        decimal_one    = '0;
        repeat (3) @(negedge CLK);
        check("reset_out", {16'd0, out}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_state", {29'd0, dut.state}, {29'd0, IDLE});
        RST_N = 1'b1;

        for (int i = 0; i < 9; i++) begin
            pulse_start(vecs[i].n, vecs[i].two, vecs[i].one, vecs[i].expected);
            wait_done(vecs[i].max_cycles, cycles);
            score($sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of a long computation.
        pulse_start(16'd16500, 16'd2, 16'd1, 16'd7);
        repeat (100) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("async_rst_out", {16'd0, out}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        void'(exp_q.pop_front());
        @(negedge CLK);
        RST_N = 1'b1;
        pulse_start(16'd9, 16'd2, 16'd1, 16'd2);
        wait_done(40000, cycles);
        score("after_reset");

        // Full 16500 run, then restart: old result must survive until the new one lands.
        pulse_start(16'd16500, 16'd2, 16'd1, 16'd7);
        wait_done(40000, cycles);
        score("n16500");
        @(negedge CLK);
        register_value = 16'd5;
        decimal_two    = 16'd2;
        decimal_one    = 16'd1;
        start          = 1'b1;
        exp_q.push_back(16'd2);
        @(negedge CLK);
        check("restart_done_drop", {31'd0, done}, 32'd0);
        check("restart_out_hold", {16'd0, out}, 32'd7);
        start    = 1'b0;
        hold_bad = 0;
        cycles   = 0;
        while (!done && cycles < 40000) begin
            if (out !== 16'd7) hold_bad++;
            @(negedge CLK);
            cycles++;
        end
        check("restart_hold_cycles", hold_bad, 0);
        score("restart");

        // Start held high keeps the engine in LOAD.
        @(negedge CLK);
        register_value = 16'd6;
        decimal_two    = 16'd2;
        decimal_one    = 16'd1;
        start          = 1'b1;
        exp_q.push_back(16'd5);
        hold_bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge CLK);
            if (done !== 1'b0 || dut.state !== LOAD) hold_bad++;
        end
        check("held_start_bad_cycles", hold_bad, 0);
        start = 1'b0;
        @(negedge CLK);
        check("held_start_release", {29'd0, dut.state}, {29'd0, INIT});
        wait_done(40000, cycles);
        score("held_start");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
